// File: rtl/frame_draw_ctrl.sv
// frame_draw_ctrl: per-frame scheduler for the frame-buffer write port.
// Each frame runs the background, sprite and score engines in that order.
// Each stage can be enabled or skipped, and each has a watchdog. The active
// engine's write bus is muxed onto the single frame-buffer port. The frame
// ends with a buffer-swap handshake.
module frame_draw_ctrl #(
    parameter int               CNT_W   = 20,
    parameter logic [CNT_W-1:0] TIMEOUT = 20'd1000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        frame_tick,
    input  logic [2:0]  stage_en,
    output logic        bg_start,
    output logic        spr_start,
    output logic        scr_start,
    input  logic        bg_done,
    input  logic        spr_done,
    input  logic        scr_done,
    input  logic        bg_we,
    input  logic        spr_we,
    input  logic        scr_we,
    input  logic [18:0] bg_addr,
    input  logic [18:0] spr_addr,
    input  logic [18:0] scr_addr,
    input  logic [31:0] bg_data,
    input  logic [31:0] spr_data,
    input  logic [31:0] scr_data,
    output logic        bg_rdy,
    output logic        spr_rdy,
    output logic        scr_rdy,
    output logic        fb_we,
    output logic [18:0] fb_addr,
    output logic [31:0] fb_data,
    input  logic        fb_rdy,
    output logic        swap_req,
    input  logic        swap_ack,
    output logic        busy,
    output logic [2:0]  timeout_err,
    output logic [7:0]  overrun_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BG_GO,
        S_BG_WAIT,
        S_SPR_GO,
        S_SPR_WAIT,
        S_SCR_GO,
        S_SCR_WAIT,
        S_SWAP
    } state_t;

    localparam logic [CNT_W-1:0] WD_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] WD_LAST = TIMEOUT - WD_ONE;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [2:0]       r_en_q;
    logic             r_pending;
    logic [CNT_W-1:0] r_wd;
    logic             w_wd_hit;
    logic             r_bg_start;
    logic             r_spr_start;
    logic             r_scr_start;
    logic             r_swap_req;
    logic             r_busy;
    logic [2:0]       r_timeout_err;
    logic [7:0]       r_overrun_cnt;

    // Lowest enabled stage in the mask; an empty mask goes straight to the swap.
    function automatic state_t first_go(input logic [2:0] en);
        if (en[0])      return S_BG_GO;
        else if (en[1]) return S_SPR_GO;
        else if (en[2]) return S_SCR_GO;
        else            return S_SWAP;
    endfunction

    // Next-state decision. A stage advances on its done pulse or on watchdog expiry.
    always_comb begin
        w_wd_hit    = (r_wd == WD_LAST);
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (frame_tick || r_pending) w_state_nxt = first_go(stage_en);
            S_BG_GO:    w_state_nxt = S_BG_WAIT;
            S_BG_WAIT:  if (bg_done || w_wd_hit) w_state_nxt = first_go({r_en_q[2:1], 1'b0});
            S_SPR_GO:   w_state_nxt = S_SPR_WAIT;
            S_SPR_WAIT: if (spr_done || w_wd_hit) w_state_nxt = first_go({r_en_q[2], 2'b00});
            S_SCR_GO:   w_state_nxt = S_SCR_WAIT;
            S_SCR_WAIT: if (scr_done || w_wd_hit) w_state_nxt = S_SWAP;
            S_SWAP:     if (swap_ack) w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Sequencer state, registered outputs, watchdog, tick bookkeeping and error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_en_q        <= 3'b000;
            r_pending     <= 1'b0;
            r_wd          <= '0;
            r_bg_start    <= 1'b0;
            r_spr_start   <= 1'b0;
            r_scr_start   <= 1'b0;
            r_swap_req    <= 1'b0;
            r_busy        <= 1'b0;
            r_timeout_err <= 3'b000;
            r_overrun_cnt <= 8'd0;
        end else begin
            r_state     <= w_state_nxt;
            // Outputs are decoded from the next state so they line up with the state register.
            r_busy      <= (w_state_nxt != S_IDLE);
            r_bg_start  <= (w_state_nxt == S_BG_GO);
            r_spr_start <= (w_state_nxt == S_SPR_GO);
            r_scr_start <= (w_state_nxt == S_SCR_GO);
            r_swap_req  <= (w_state_nxt == S_SWAP);

            case (r_state)
                S_BG_GO, S_SPR_GO, S_SCR_GO:       r_wd <= '0;
                S_BG_WAIT, S_SPR_WAIT, S_SCR_WAIT: r_wd <= r_wd + WD_ONE;
                default:                           r_wd <= r_wd;
            endcase

            if (r_state == S_BG_WAIT  && !bg_done  && w_wd_hit) r_timeout_err[0] <= 1'b1;
            if (r_state == S_SPR_WAIT && !spr_done && w_wd_hit) r_timeout_err[1] <= 1'b1;
            if (r_state == S_SCR_WAIT && !scr_done && w_wd_hit) r_timeout_err[2] <= 1'b1;

            if (r_state == S_IDLE) begin
                if (frame_tick || r_pending) begin
                    r_en_q    <= stage_en;
                    r_pending <= 1'b0;
                    // A fresh tick on top of a pending one is one frame lost.
                    if (frame_tick && r_pending && r_overrun_cnt != 8'hFF)
                        r_overrun_cnt <= r_overrun_cnt + 8'd1;
                end
            end else if (frame_tick) begin
                if (!r_pending)
                    r_pending <= 1'b1;
                else if (r_overrun_cnt != 8'hFF)
                    r_overrun_cnt <= r_overrun_cnt + 8'd1;
            end
        end
    end

    // Zero-latency write-port mux; only the engine in its WAIT state sees fb_rdy.
    always_comb begin
        fb_we   = 1'b0;
        fb_addr = 19'd0;
        fb_data = 32'd0;
        bg_rdy  = 1'b0;
        spr_rdy = 1'b0;
        scr_rdy = 1'b0;
        case (r_state)
            S_BG_WAIT: begin
                fb_we   = bg_we;
                fb_addr = bg_addr;
                fb_data = bg_data;
                bg_rdy  = fb_rdy;
            end
            S_SPR_WAIT: begin
                fb_we   = spr_we;
                fb_addr = spr_addr;
                fb_data = spr_data;
                spr_rdy = fb_rdy;
            end
            S_SCR_WAIT: begin
                fb_we   = scr_we;
                fb_addr = scr_addr;
                fb_data = scr_data;
                scr_rdy = fb_rdy;
            end
            default: begin
                fb_we   = 1'b0;
            end
        endcase
    end

    assign bg_start    = r_bg_start;
    assign spr_start   = r_spr_start;
    assign scr_start   = r_scr_start;
    assign swap_req    = r_swap_req;
    assign busy        = r_busy;
    assign timeout_err = r_timeout_err;
    assign overrun_cnt = r_overrun_cnt;

endmodule

// File: tb/tb_frame_draw_ctrl.sv
// Directed testbench for frame_draw_ctrl, built with a short watchdog (TIMEOUT=50).
module tb_frame_draw_ctrl;

    logic        clk;
    logic        rst;
    logic        frame_tick;
    logic [2:0]  stage_en;
    logic        bg_start, spr_start, scr_start;
    logic        bg_done, spr_done, scr_done;
    logic        bg_we, spr_we, scr_we;
    logic [18:0] bg_addr, spr_addr, scr_addr;
    logic [31:0] bg_data, spr_data, scr_data;
    logic        bg_rdy, spr_rdy, scr_rdy;
    logic        fb_we;
    logic [18:0] fb_addr;
    logic [31:0] fb_data;
    logic        fb_rdy;
    logic        swap_req;
    logic        swap_ack;
    logic        busy;
    logic [2:0]  timeout_err;
    logic [7:0]  overrun_cnt;

    int n_asrt = 0;
    int n_fail = 0;

    frame_draw_ctrl #(
        .CNT_W   (20),
        .TIMEOUT (20'd50)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .stage_en    (stage_en),
        .bg_start    (bg_start),
        .spr_start   (spr_start),
        .scr_start   (scr_start),
        .bg_done     (bg_done),
        .spr_done    (spr_done),
        .scr_done    (scr_done),
        .bg_we       (bg_we),
        .spr_we      (spr_we),
        .scr_we      (scr_we),
        .bg_addr     (bg_addr),
        .spr_addr    (spr_addr),
        .scr_addr    (scr_addr),
        .bg_data     (bg_data),
        .spr_data    (spr_data),
        .scr_data    (scr_data),
        .bg_rdy      (bg_rdy),
        .spr_rdy     (spr_rdy),
        .scr_rdy     (scr_rdy),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .fb_rdy      (fb_rdy),
        .swap_req    (swap_req),
        .swap_ack    (swap_ack),
        .busy        (busy),
        .timeout_err (timeout_err),
        .overrun_cnt (overrun_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asrt++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic pulse_done(input int which);
        case (which)
            0: bg_done  = 1'b1;
            1: spr_done = 1'b1;
            default: scr_done = 1'b1;
        endcase
        step();
        bg_done  = 1'b0;
        spr_done = 1'b0;
        scr_done = 1'b0;
    endtask

    task automatic ack();
        swap_ack = 1'b1;
        step();
        swap_ack = 1'b0;
    endtask

    initial begin
        rst = 1'b1; frame_tick = 1'b0; stage_en = 3'b000;
        bg_done = 1'b0; spr_done = 1'b0; scr_done = 1'b0;
        bg_we = 1'b0; spr_we = 1'b0; scr_we = 1'b0;
        bg_addr = '0; spr_addr = '0; scr_addr = '0;
        bg_data = '0; spr_data = '0; scr_data = '0;
        fb_rdy = 1'b0; swap_ack = 1'b0;

        // Reset state
        step(); step();
        chk("rst_busy",     32'(busy),        32'd0);
        chk("rst_starts",   32'({bg_start, spr_start, scr_start}), 32'd0);
        chk("rst_swap_req", 32'(swap_req),    32'd0);
        chk("rst_fb_we",    32'(fb_we),       32'd0);
        chk("rst_tmo",      32'(timeout_err), 32'd0);
        chk("rst_ovr",      32'(overrun_cnt), 32'd0);
        rst = 1'b0;
        step();

        // Nominal frame, all stages enabled
        stage_en = 3'b111;
        tick();
        chk("nom_bg_start", 32'({bg_start, spr_start, scr_start}), 32'b100);
        chk("nom_busy",     32'(busy), 32'd1);
        step();
        chk("nom_bg_pulse", 32'(bg_start), 32'd0);
        bg_we = 1'b1; bg_addr = 19'h0ABCD; bg_data = 32'h12345678; fb_rdy = 1'b1;
        #1;
        chk("bg_mux_addr", 32'(fb_addr), 32'h0ABCD);
        chk("bg_mux_rdy",  32'({bg_rdy, spr_rdy, scr_rdy}), 32'b100);
        bg_we = 1'b0; bg_addr = '0; bg_data = '0; fb_rdy = 1'b0;
        repeat (8) step();
        pulse_done(0);
        chk("nom_spr_start", 32'({bg_start, spr_start, scr_start}), 32'b010);
        step();
        repeat (8) step();
        pulse_done(1);
        chk("nom_scr_start", 32'({bg_start, spr_start, scr_start}), 32'b001);
        step();

        // Write-port mux in SCR_WAIT, with a competing bg request
        scr_we = 1'b1; scr_addr = 19'h00123; scr_data = 32'hFF00FF00; fb_rdy = 1'b1;
        bg_we = 1'b1; bg_addr = 19'h7FFFF; bg_data = 32'hDEADBEEF;
        #1;
        chk("mux_fb_we",   32'(fb_we),   32'd1);
        chk("mux_fb_addr", 32'(fb_addr), 32'h00123);
        chk("mux_fb_data", fb_data,      32'hFF00FF00);
        chk("mux_rdy",     32'({bg_rdy, spr_rdy, scr_rdy}), 32'b001);
        scr_we = 1'b0; scr_addr = '0; scr_data = '0; fb_rdy = 1'b0;
        bg_we = 1'b0; bg_addr = '0; bg_data = '0;
        repeat (7) step();
        pulse_done(2);
        chk("nom_swap_rise", 32'(swap_req), 32'd1);
        chk("nom_swap_busy", 32'(busy),     32'd1);
        chk("swap_fb_we",    32'(fb_we),    32'd0);
        step();
        chk("nom_swap_hold", 32'(swap_req), 32'd1);
        ack();
        chk("nom_swap_fall", 32'(swap_req),    32'd0);
        chk("nom_idle_busy", 32'(busy),        32'd0);
        chk("nom_no_tmo",    32'(timeout_err), 32'd0);

        // Done pulse while idle is ignored
        pulse_done(0);
        chk("idle_done_ign", 32'({busy, bg_start, spr_start, scr_start}), 32'd0);

        // Stage skip: score only
        stage_en = 3'b100;
        tick();
        chk("skip_scr_only", 32'({bg_start, spr_start, scr_start}), 32'b001);
        step();
        pulse_done(2);
        chk("skip_swap", 32'(swap_req), 32'd1);
        ack();

        // Stage skip: nothing enabled goes straight to swap
        stage_en = 3'b000;
        tick();
        chk("none_swap",   32'(swap_req), 32'd1);
        chk("none_starts", 32'({bg_start, spr_start, scr_start}), 32'd0);
        ack();
        chk("none_idle", 32'(busy), 32'd0);

        // Sprite watchdog timeout
        stage_en = 3'b111;
        tick();
        step();
        pulse_done(0);
        chk("tmo_spr_start", 32'(spr_start), 32'd1);
        step();
        repeat (49) step();
        chk("tmo_not_yet",   32'({timeout_err, scr_start}), 32'd0);
        step();
        chk("tmo_flag",      32'(timeout_err), 32'b010);
        chk("tmo_scr_start", 32'(scr_start),   32'd1);
        step();
        pulse_done(2);
        ack();
        chk("tmo_sticky", 32'(timeout_err), 32'b010);
        chk("tmo_idle",   32'(busy),        32'd0);

        // Overrun: three ticks during one frame
        stage_en = 3'b001;
        tick();
        step();
        tick(); tick(); tick();
        chk("ovr_cnt2", 32'(overrun_cnt), 32'd2);
        pulse_done(0);
        chk("ovr_swap", 32'(swap_req), 32'd1);
        ack();
        chk("ovr_idle",  32'(busy), 32'd0);
        step();
        chk("ovr_restart", 32'({busy, bg_start}), 32'b11);
        chk("ovr_keep2",   32'(overrun_cnt), 32'd2);
        step();
        pulse_done(0);
        frame_tick = 1'b1;
        repeat (300) step();
        frame_tick = 1'b0;
        chk("ovr_sat",       32'(overrun_cnt), 32'd255);
        chk("ovr_swap_hold", 32'(swap_req),    32'd1);

        // Reset mid-frame in SPR_WAIT
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_ovr",  32'(overrun_cnt), 32'd0);
        chk("rst2_tmo",  32'(timeout_err), 32'd0);
        chk("rst2_busy", 32'({busy, swap_req}), 32'd0);
        step();
        chk("rst2_no_pending", 32'(busy), 32'd0);
        stage_en = 3'b111;
        tick();
        step();
        pulse_done(0);
        step();
        spr_we = 1'b1; spr_addr = 19'h00042; spr_data = 32'hCAFEF00D; fb_rdy = 1'b1;
        #1;
        chk("spr_mux_data", fb_data, 32'hCAFEF00D);
        chk("spr_mux_rdy",  32'({bg_rdy, spr_rdy, scr_rdy}), 32'b010);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst3_busy",  32'(busy),    32'd0);
        chk("rst3_fb_we", 32'(fb_we),   32'd0);
        chk("rst3_rdy",   32'(spr_rdy), 32'd0);
        chk("rst3_addr",  32'(fb_addr), 32'd0);
        spr_we = 1'b0; spr_addr = '0; spr_data = '0; fb_rdy = 1'b0;
        pulse_done(1);
        chk("rst3_stale_done", 32'({busy, bg_start, spr_start, scr_start, swap_req}), 32'd0);
        step();
        chk("rst3_still_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
